// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared constants and types for the pipeline hazard controller:
//           operand forwarding selects, controller state encodings and a
//           helper that turns the load-stall depth into a counter preset.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file read
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // result held in the EX/MEM latch
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // result held in the MEM/WB latch

  // Controller states
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Counter preset loaded on entry to STALL: the detection cycle already
  // supplies the first bubble, so the counter covers the remaining ones.
  function automatic logic [2:0] stall_preset(input int unsigned depth);
    int unsigned d;
    d = (depth < 1) ? 1 : ((depth > 7) ? 7 : depth);
    return 3'(d - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_fwd_select.sv
`default_nettype none
// ============================================================================
// Module  : fwd_select
// Brief   : Picks the source of one EX-stage operand. The writer in MEM is
//           younger than the one in WB, so it wins when both target the id.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_W = 2
) (
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_rw,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_rw,
  output logic [1:0]       o_sel
);

  // Youngest matching writer supplies the operand
  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_rw && (i_mem_rd == i_src)) begin
      o_sel = FWD_EXMEM;
    end else if (i_wb_rw && (i_wb_rd == i_src)) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_unit
// Brief   : Pipeline control for the 8-bit, 4-register core. Drives the
//           Fetch/Decode and Decode/Execute latch load/flush and PC load,
//           resolving load-use stalls, taken-branch flushes and HLT, and
//           produces the EX operand forwarding selects.
// Config  : HAZARD_FWD_EN - when defined, EX operands are forwarded from
//           EX/MEM and MEM/WB and only loads stall (for LOAD_STALL cycles).
//           When undefined, forwarding selects stay at the register file and
//           any decode source pending in EX or MEM stalls one cycle at a
//           time, re-evaluated every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int REG_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_ra,
  input  logic [REG_W-1:0] d_rb,
  input  logic             d_use_ra,
  input  logic             d_use_rb,
  input  logic [REG_W-1:0] ex_ra,
  input  logic [REG_W-1:0] ex_rb,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_RW,
  input  logic             ex_MR,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_RW,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_RW,
  input  logic             br_taken,
  input  logic             ex_Hlt,
  output logic             pc_ld,
  output logic             fd_ld,
  output logic             fd_flush,
  output logic             dex_ld,
  output logic             dex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted
);

  localparam logic [2:0] CNT_PRESET = stall_preset(LOAD_STALL);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  logic       w_src_in_ex;   // a decode source matches the EX destination
  logic       w_load_use;    // decode must wait this cycle
  logic       w_multi;       // hazard needs the STALL state (multi-bubble)
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  logic       w_pc_ld;
  logic       w_fd_ld;
  logic       w_fd_flush;
  logic       w_dex_ld;
  logic       w_dex_flush;
  logic       w_halted;

  assign w_src_in_ex = (d_use_ra && (d_ra == ex_rd)) ||
                       (d_use_rb && (d_rb == ex_rd));

`ifdef HAZARD_FWD_EN
  // Only a load cannot be forwarded in time; everything else is bypassed.
  assign w_load_use = ex_MR && ex_RW && w_src_in_ex;
  assign w_multi    = (CNT_PRESET != 3'd0);

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .i_src    (ex_ra),
    .i_mem_rd (mem_rd),
    .i_mem_rw (mem_RW),
    .i_wb_rd  (wb_rd),
    .i_wb_rw  (wb_RW),
    .o_sel    (w_fwd_a)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .i_src    (ex_rb),
    .i_mem_rd (mem_rd),
    .i_mem_rw (mem_RW),
    .i_wb_rd  (wb_rd),
    .i_wb_rw  (wb_RW),
    .o_sel    (w_fwd_b)
  );
`else
  logic w_src_in_mem;
  logic w_unused;

  // Without bypass paths the decode stage waits until the producer has
  // reached WB; WB writes the regfile in the first half-cycle, so WB itself
  // never blocks a decode read.
  assign w_src_in_mem = (d_use_ra && (d_ra == mem_rd)) ||
                        (d_use_rb && (d_rb == mem_rd));
  assign w_load_use   = (ex_RW && w_src_in_ex) || (mem_RW && w_src_in_mem);
  assign w_multi      = 1'b0;
  assign w_fwd_a      = FWD_RF;
  assign w_fwd_b      = FWD_RF;
  assign w_unused     = ^{ex_ra, ex_rb, wb_rd, wb_RW, ex_MR, CNT_PRESET};
`endif

  // State and bubble counter; reset may arrive at any time, including mid-stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and latch controls; priority HALT > HLT > branch > stall > run
  always_comb begin
    w_state_nxt = ST_RUN;
    w_cnt_nxt   = 3'd0;
    w_pc_ld     = 1'b1;
    w_fd_ld     = 1'b1;
    w_fd_flush  = 1'b0;
    w_dex_ld    = 1'b1;
    w_dex_flush = 1'b0;
    w_halted    = 1'b0;

    if (r_state == ST_HALT) begin
      w_state_nxt = ST_HALT;
      w_pc_ld     = 1'b0;
      w_fd_ld     = 1'b0;
      w_dex_flush = 1'b1;
      w_halted    = 1'b1;
    end else if (ex_Hlt) begin
      // Freeze fetch, drain HLT out of EX with a bubble, then halt
      w_state_nxt = ST_HALT;
      w_pc_ld     = 1'b0;
      w_fd_ld     = 1'b0;
      w_dex_flush = 1'b1;
    end else if (br_taken) begin
      // Load the target and squash both wrong-path instructions
      w_fd_flush  = 1'b1;
      w_dex_flush = 1'b1;
    end else if (r_state == ST_STALL) begin
      w_pc_ld     = 1'b0;
      w_fd_ld     = 1'b0;
      w_dex_flush = 1'b1;
      if (r_cnt > 3'd1) begin
        w_state_nxt = ST_STALL;
        w_cnt_nxt   = r_cnt - 3'd1;
      end
    end else if (w_load_use) begin
      w_pc_ld     = 1'b0;
      w_fd_ld     = 1'b0;
      w_dex_flush = 1'b1;
      if (w_multi) begin
        w_state_nxt = ST_STALL;
        w_cnt_nxt   = CNT_PRESET;
      end
    end
  end

  // While reset is held the pipeline is frozen and both latches are flushed
  assign pc_ld     = reset && w_pc_ld;
  assign fd_ld     = reset && w_fd_ld;
  assign dex_ld    = reset && w_dex_ld;
  assign fd_flush  = !reset || w_fd_flush;
  assign dex_flush = !reset || w_dex_flush;
  assign halted    = reset && w_halted;
  assign fwd_a     = reset ? w_fwd_a : FWD_RF;
  assign fwd_b     = reset ? w_fwd_b : FWD_RF;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl_unit
// Brief   : Self-checking bench for hazard_ctrl_unit. Two instances share
//           stimulus: one with a single load bubble, one with three.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       rst_n;
    logic [1:0] d_ra;
    logic [1:0] d_rb;
    logic       d_use_ra;
    logic       d_use_rb;
    logic [1:0] ex_ra;
    logic [1:0] ex_rb;
    logic [1:0] ex_rd;
    logic       ex_RW;
    logic       ex_MR;
    logic [1:0] mem_rd;
    logic       mem_RW;
    logic [1:0] wb_rd;
    logic       wb_RW;
    logic       br;
    logic       hlt;
  } in_t;

  // {pc_ld, fd_ld, fd_flush, dex_ld, dex_flush, halted, fwd_a, fwd_b}
  typedef logic [9:0] ov_t;

  localparam ov_t RUNV  = 10'b1101000000;
  localparam ov_t STLV  = 10'b0001100000;
  localparam ov_t BRV   = 10'b1111100000;
  localparam ov_t HALTV = 10'b0001110000;
  localparam ov_t RSTV  = 10'b0010100000;

  logic clk = 1'b0;
  in_t  tin = '0;
  int   n_checks = 0;
  int   n_errors = 0;
  ov_t  q1[$];
  ov_t  q3[$];

  logic pc1, fdl1, fdf1, dxl1, dxf1, h1;
  logic [1:0] fa1, fb1;
  logic pc3, fdl3, fdf3, dxl3, dxf3, h3;
  logic [1:0] fa3, fb3;
  ov_t  o1, o3;

  assign o1 = {pc1, fdl1, fdf1, dxl1, dxf1, h1, fa1, fb1};
  assign o3 = {pc3, fdl3, fdf3, dxl3, dxf3, h3, fa3, fb3};

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.LOAD_STALL(1), .REG_W(2)) u_dut (
    .clk(clk), .reset(tin.rst_n),
    .d_ra(tin.d_ra), .d_rb(tin.d_rb), .d_use_ra(tin.d_use_ra), .d_use_rb(tin.d_use_rb),
    .ex_ra(tin.ex_ra), .ex_rb(tin.ex_rb), .ex_rd(tin.ex_rd), .ex_RW(tin.ex_RW), .ex_MR(tin.ex_MR),
    .mem_rd(tin.mem_rd), .mem_RW(tin.mem_RW), .wb_rd(tin.wb_rd), .wb_RW(tin.wb_RW),
    .br_taken(tin.br), .ex_Hlt(tin.hlt),
    .pc_ld(pc1), .fd_ld(fdl1), .fd_flush(fdf1), .dex_ld(dxl1), .dex_flush(dxf1),
    .fwd_a(fa1), .fwd_b(fb1), .halted(h1)
  );

  hazard_ctrl_unit #(.LOAD_STALL(3), .REG_W(2)) u_dut3 (
    .clk(clk), .reset(tin.rst_n),
    .d_ra(tin.d_ra), .d_rb(tin.d_rb), .d_use_ra(tin.d_use_ra), .d_use_rb(tin.d_use_rb),
    .ex_ra(tin.ex_ra), .ex_rb(tin.ex_rb), .ex_rd(tin.ex_rd), .ex_RW(tin.ex_RW), .ex_MR(tin.ex_MR),
    .mem_rd(tin.mem_rd), .mem_RW(tin.mem_RW), .wb_rd(tin.wb_rd), .wb_RW(tin.wb_RW),
    .br_taken(tin.br), .ex_Hlt(tin.hlt),
    .pc_ld(pc3), .fd_ld(fdl3), .fd_flush(fdf3), .dex_ld(dxl3), .dex_flush(dxf3),
    .fwd_a(fa3), .fwd_b(fb3), .halted(h3)
  );

  function automatic in_t idle();
    in_t t;
    t = '0;
    t.rst_n = 1'b1;
    return t;
  endfunction

  function automatic in_t load_haz();
    in_t t;
    t = idle();
    t.ex_MR = 1'b1; t.ex_RW = 1'b1; t.ex_rd = 2'd2;
    t.d_ra = 2'd2; t.d_use_ra = 1'b1;
    return t;
  endfunction

  function automatic ov_t fw(input ov_t b, input logic [1:0] a, input logic [1:0] c);
    return {b[9:4], a, c};
  endfunction

  task automatic test_reset();
    in_t st[10];
    ov_t e1[10], e3[10];
    ov_t ex;
    st[0] = '0;         e1[0] = RSTV; e3[0] = RSTV;
    st[1] = '0;         e1[1] = RSTV; e3[1] = RSTV;
    st[2] = idle();     e1[2] = RUNV; e3[2] = RUNV;
    st[3] = load_haz(); e1[3] = STLV; e3[3] = STLV;
    st[4] = idle();     e1[4] = RUNV; e3[4] = FWD ? STLV : RUNV;
    st[5] = '0;         e1[5] = RSTV; e3[5] = RSTV;
    st[6] = '0;         e1[6] = RSTV; e3[6] = RSTV;
    st[7] = '0;         e1[7] = RSTV; e3[7] = RSTV;
    st[8] = idle();     e1[8] = RUNV; e3[8] = RUNV;
    st[9] = idle();     e1[9] = RUNV; e3[9] = RUNV;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tin = st[i]; q1.push_back(e1[i]); q3.push_back(e3[i]);
      @(negedge clk);
      ex = q1.pop_front(); n_checks++;
      if (o1 !== ex) begin n_errors++; $display("FAIL reset[%0d] ls1: got %b want %b", i, o1, ex); end
      ex = q3.pop_front(); n_checks++;
      if (o3 !== ex) begin n_errors++; $display("FAIL reset[%0d] ls3: got %b want %b", i, o3, ex); end
    end
  endtask

  task automatic test_load_use();
    in_t st[6];
    ov_t e1[6], e3[6];
    ov_t ex;
    st[0] = load_haz(); st[0].ex_RW = 1'b0;
    e1[0] = RUNV; e3[0] = RUNV;
    st[1] = load_haz(); st[1].d_use_ra = 1'b0; st[1].d_rb = 2'd1; st[1].d_use_rb = 1'b1;
    e1[1] = RUNV; e3[1] = RUNV;
    st[2] = load_haz();
    e1[2] = STLV; e3[2] = STLV;
    st[3] = idle(); st[3].mem_rd = 2'd2; st[3].mem_RW = 1'b1; st[3].d_ra = 2'd2; st[3].d_use_ra = 1'b1;
    e1[3] = FWD ? RUNV : STLV; e3[3] = STLV;
    st[4] = idle(); st[4].ex_ra = 2'd2; st[4].mem_rd = 2'd2; st[4].mem_RW = 1'b1;
    e1[4] = FWD ? fw(RUNV, 2'b01, 2'b00) : RUNV;
    e3[4] = FWD ? fw(STLV, 2'b01, 2'b00) : RUNV;
    st[5] = idle();
    e1[5] = RUNV; e3[5] = RUNV;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      tin = st[i]; q1.push_back(e1[i]); q3.push_back(e3[i]);
      @(negedge clk);
      ex = q1.pop_front(); n_checks++;
      if (o1 !== ex) begin n_errors++; $display("FAIL load_use[%0d] ls1: got %b want %b", i, o1, ex); end
      ex = q3.pop_front(); n_checks++;
      if (o3 !== ex) begin n_errors++; $display("FAIL load_use[%0d] ls3: got %b want %b", i, o3, ex); end
    end
  endtask

  task automatic test_stall_branch();
    in_t st[5];
    ov_t e1[5], e3[5];
    ov_t ex;
    st[0] = load_haz();               e1[0] = STLV; e3[0] = STLV;
    st[1] = idle(); st[1].br = 1'b1;  e1[1] = BRV;  e3[1] = BRV;
    st[2] = idle();                   e1[2] = RUNV; e3[2] = RUNV;
    st[3] = load_haz(); st[3].br = 1'b1; e1[3] = BRV; e3[3] = BRV;
    st[4] = idle();                   e1[4] = RUNV; e3[4] = RUNV;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tin = st[i]; q1.push_back(e1[i]); q3.push_back(e3[i]);
      @(negedge clk);
      ex = q1.pop_front(); n_checks++;
      if (o1 !== ex) begin n_errors++; $display("FAIL stall_branch[%0d] ls1: got %b want %b", i, o1, ex); end
      ex = q3.pop_front(); n_checks++;
      if (o3 !== ex) begin n_errors++; $display("FAIL stall_branch[%0d] ls3: got %b want %b", i, o3, ex); end
    end
  endtask

  task automatic test_forward();
    in_t st[5];
    ov_t e[5];
    ov_t ex;
    st[0] = idle(); st[0].ex_rb = 2'd1; st[0].mem_rd = 2'd1; st[0].mem_RW = 1'b1;
    st[0].wb_rd = 2'd1; st[0].wb_RW = 1'b1;
    e[0] = FWD ? fw(RUNV, 2'b00, 2'b01) : RUNV;
    st[1] = st[0]; st[1].mem_RW = 1'b0;
    e[1] = FWD ? fw(RUNV, 2'b00, 2'b10) : RUNV;
    st[2] = st[1]; st[2].ex_rb = 2'd3;
    e[2] = RUNV;
    st[3] = idle(); st[3].ex_ra = 2'd2; st[3].ex_rb = 2'd2; st[3].mem_rd = 2'd2; st[3].mem_RW = 1'b1;
    st[3].wb_rd = 2'd2; st[3].wb_RW = 1'b1;
    e[3] = FWD ? fw(RUNV, 2'b01, 2'b01) : RUNV;
    st[4] = idle(); st[4].ex_ra = 2'd3; st[4].wb_rd = 2'd3; st[4].wb_RW = 1'b1; st[4].mem_RW = 1'b1;
    e[4] = FWD ? fw(RUNV, 2'b10, 2'b01) : RUNV;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tin = st[i]; q1.push_back(e[i]); q3.push_back(e[i]);
      @(negedge clk);
      ex = q1.pop_front(); n_checks++;
      if (o1 !== ex) begin n_errors++; $display("FAIL forward[%0d] ls1: got %b want %b", i, o1, ex); end
      ex = q3.pop_front(); n_checks++;
      if (o3 !== ex) begin n_errors++; $display("FAIL forward[%0d] ls3: got %b want %b", i, o3, ex); end
    end
  endtask

  task automatic test_halt();
    in_t st[24];
    ov_t e[24];
    ov_t ex;
    st[0] = idle(); st[0].hlt = 1'b1; st[0].br = 1'b1; e[0] = STLV;
    for (int i = 1; i <= 20; i++) begin
      st[i] = (i % 3 == 0) ? load_haz() : idle();
      st[i].br = (i % 2 == 1);
      e[i] = HALTV;
    end
    st[21] = '0; e[21] = RSTV;
    st[22] = '0; e[22] = RSTV;
    st[23] = idle(); e[23] = RUNV;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      tin = st[i]; q1.push_back(e[i]); q3.push_back(e[i]);
      @(negedge clk);
      ex = q1.pop_front(); n_checks++;
      if (o1 !== ex) begin n_errors++; $display("FAIL halt[%0d] ls1: got %b want %b", i, o1, ex); end
      ex = q3.pop_front(); n_checks++;
      if (o3 !== ex) begin n_errors++; $display("FAIL halt[%0d] ls3: got %b want %b", i, o3, ex); end
    end
  endtask

  task automatic test_nofwd_stall();
    in_t st[6];
    ov_t e[6];
    ov_t ex;
    st[0] = idle(); st[0].mem_rd = 2'd3; st[0].mem_RW = 1'b1; st[0].d_rb = 2'd3; st[0].d_use_rb = 1'b1;
    e[0] = FWD ? RUNV : STLV;
    st[1] = st[0];
    e[1] = FWD ? RUNV : STLV;
    st[2] = idle(); st[2].ex_rd = 2'd1; st[2].ex_RW = 1'b1; st[2].d_ra = 2'd1; st[2].d_use_ra = 1'b1;
    e[2] = FWD ? RUNV : STLV;
    st[3] = st[0]; st[3].d_use_rb = 1'b0;
    e[3] = RUNV;
    st[4] = st[0]; st[4].mem_RW = 1'b0;
    e[4] = RUNV;
    st[5] = idle(); st[5].mem_rd = 2'd3; st[5].mem_RW = 1'b1; st[5].ex_rb = 2'd3;
    e[5] = FWD ? fw(RUNV, 2'b00, 2'b01) : RUNV;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      tin = st[i]; q1.push_back(e[i]); q3.push_back(e[i]);
      @(negedge clk);
      ex = q1.pop_front(); n_checks++;
      if (o1 !== ex) begin n_errors++; $display("FAIL nofwd[%0d] ls1: got %b want %b", i, o1, ex); end
      ex = q3.pop_front(); n_checks++;
      if (o3 !== ex) begin n_errors++; $display("FAIL nofwd[%0d] ls3: got %b want %b", i, o3, ex); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_stall_branch();
    test_forward();
    test_halt();
    test_nofwd_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, limit 100000 reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
